cr_huf_comp_is_arb: RTL and testbench

Block-granular round-robin arbiter that shares one long-symbol insertion-sort engine (`cr_huf_comp_is` in its long configuration) between two symbol-count producers. It sits between the two symbol-counter output ports and the sort engine's input. It locks the grant to one producer for a whole block (first word through `eob`) and buffers forwarded words in a 2-entry output FIFO. It also flags a sequence-ID change inside a block.

---
 rtl/cr_huf_comp_is_arb_pkg.sv | 22 ++
 rtl/cr_huf_comp_is_arb_fifo.sv | 47 ++++
 rtl/cr_huf_comp_is_arb.sv | 155 +++++++++++++++
 tb/tb_cr_huf_comp_is_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_comp_is_arb_pkg.sv
// rtl/cr_huf_comp_is_arb_pkg.sv - shared types for the long-symbol sort engine arbiter
package cr_huf_compPKG;

    localparam int DAT_W   = 8;
    localparam int CNT_W   = 16;
    localparam int SEQID_W = 8;

    typedef struct packed {
        logic [DAT_W-1:0]   sym;
        logic [CNT_W-1:0]   cnt;
        logic [SEQID_W-1:0] seq_id;
        logic               eob;
        logic               src;
    } s_is_arb_word;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } e_is_arb_state;

endpackage

// File: rtl/cr_huf_comp_is_arb_fifo.sv
// rtl/cr_huf_comp_is_arb_fifo.sv - 2-entry word FIFO, push and pop legal together at any fill
module cr_huf_comp_is_arb_fifo
    import cr_huf_compPKG::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  s_is_arb_word push_word,
    input  logic         pop,
    output s_is_arb_word head,
    output logic [1:0]   cnt
);

    s_is_arb_word mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (cnt_q != 2'd0);
    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head = mem[rd_ptr];
    assign cnt  = cnt_q;

endmodule

// File: rtl/cr_huf_comp_is_arb.sv
// rtl/cr_huf_comp_is_arb.sv - block-locked round-robin arbiter in front of the long sort engine
module cr_huf_comp_is_arb
    import cr_huf_compPKG::*;
#(
    parameter int DAT_WIDTH   = DAT_W,
    parameter int CNT_WIDTH   = CNT_W,
    parameter int SEQID_WIDTH = SEQID_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_vld,
    input  logic [DAT_WIDTH-1:0]   req0_sym,
    input  logic [CNT_WIDTH-1:0]   req0_cnt,
    input  logic [SEQID_WIDTH-1:0] req0_seq_id,
    input  logic                   req0_eob,
    output logic                   req0_rd,
    input  logic                   req1_vld,
    input  logic [DAT_WIDTH-1:0]   req1_sym,
    input  logic [CNT_WIDTH-1:0]   req1_cnt,
    input  logic [SEQID_WIDTH-1:0] req1_seq_id,
    input  logic                   req1_eob,
    output logic                   req1_rd,
    output logic                   arb_is_vld,
    output logic [DAT_WIDTH-1:0]   arb_is_sym,
    output logic [CNT_WIDTH-1:0]   arb_is_cnt,
    output logic [SEQID_WIDTH-1:0] arb_is_seq_id,
    output logic                   arb_is_eob,
    output logic                   arb_is_src,
    input  logic                   is_arb_rd,
    output logic                   blk_done,
    output logic                   blk_done_src,
    output logic                   err_seq
);

    e_is_arb_state          state_q, state_d;
    logic                   rr_q;
    logic [SEQID_WIDTH-1:0] rec_id_q;
    logic                   err_q;
    logic                   done_q;
    logic                   done_src_q;

    s_is_arb_word           head;
    s_is_arb_word           push_word;
    logic [1:0]             fifo_cnt;
    logic                   fifo_vld;
    logic                   eng_pop;
    logic                   room;
    logic                   push;
    logic                   lock_src;
    logic                   grant_vld;
    logic                   grant_src;
    logic [SEQID_WIDTH-1:0] grant_seq;

    logic                   cur_vld;
    logic                   cur_eob;
    logic [SEQID_WIDTH-1:0] cur_seq;

    assign fifo_vld  = (fifo_cnt != 2'd0);
    assign eng_pop   = is_arb_rd && fifo_vld;
    assign room      = (fifo_cnt < 2'd2) || eng_pop;
    assign lock_src  = (state_q == LOCK1);
    assign cur_vld   = lock_src ? req1_vld    : req0_vld;
    assign cur_eob   = lock_src ? req1_eob    : req0_eob;
    assign cur_seq   = lock_src ? req1_seq_id : req0_seq_id;
    assign grant_seq = grant_src ? req1_seq_id : req0_seq_id;

    always_comb begin
        push_word.sym    = lock_src ? req1_sym : req0_sym;
        push_word.cnt    = lock_src ? req1_cnt : req0_cnt;
        push_word.seq_id = cur_seq;
        push_word.eob    = cur_eob;
        push_word.src    = lock_src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req0_rd   = 1'b0;
        req1_rd   = 1'b0;
        push      = 1'b0;
        grant_vld = 1'b0;
        grant_src = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_vld || req1_vld) begin
                    grant_vld = 1'b1;
                    grant_src = (req0_vld && req1_vld) ? rr_q : req1_vld;
                    state_d   = grant_src ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                push    = cur_vld && room;
                req0_rd = push && !lock_src;
                req1_rd = push && lock_src;
                if (push && cur_eob) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= 1'b0;
            rec_id_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            done_src_q <= 1'b0;
        end else begin
            if (grant_vld) begin
                rec_id_q <= grant_seq;
            end
            if (push && (cur_seq != rec_id_q)) begin
                err_q <= 1'b1;
            end
            if (push && cur_eob) begin
                rr_q <= ~lock_src;
            end
            done_q <= eng_pop && head.eob;
            if (eng_pop && head.eob) begin
                done_src_q <= head.src;
            end
        end
    end

    cr_huf_comp_is_arb_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_word (push_word),
        .pop       (eng_pop),
        .head      (head),
        .cnt       (fifo_cnt)
    );

    // Data outputs read as zero while the FIFO is empty so stale entries never leak out
    assign arb_is_vld    = fifo_vld;
    assign arb_is_sym    = fifo_vld ? head.sym    : '0;
    assign arb_is_cnt    = fifo_vld ? head.cnt    : '0;
    assign arb_is_seq_id = fifo_vld ? head.seq_id : '0;
    assign arb_is_eob    = fifo_vld && head.eob;
    assign arb_is_src    = fifo_vld && head.src;
    assign blk_done      = done_q;
    assign blk_done_src  = done_src_q;
    assign err_seq       = err_q;

endmodule

// File: tb/tb_cr_huf_comp_is_arb.sv
// tb/tb_cr_huf_comp_is_arb.sv - self-checking bench for cr_huf_comp_is_arb
module tb_cr_huf_comp_is_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [7:0]  req0_sym, req1_sym;
    logic [15:0] req0_cnt, req1_cnt;
    logic [7:0]  req0_seq_id, req1_seq_id;
    logic        req0_eob, req1_eob;
    logic        req0_rd, req1_rd;
    logic        arb_is_vld;
    logic [7:0]  arb_is_sym;
    logic [15:0] arb_is_cnt;
    logic [7:0]  arb_is_seq_id;
    logic        arb_is_eob, arb_is_src;
    logic        is_arb_rd;
    logic        blk_done, blk_done_src, err_seq;

    always #5 clk = ~clk;

    cr_huf_comp_is_arb dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_sym(req0_sym), .req0_cnt(req0_cnt),
        .req0_seq_id(req0_seq_id), .req0_eob(req0_eob), .req0_rd(req0_rd),
        .req1_vld(req1_vld), .req1_sym(req1_sym), .req1_cnt(req1_cnt),
        .req1_seq_id(req1_seq_id), .req1_eob(req1_eob), .req1_rd(req1_rd),
        .arb_is_vld(arb_is_vld), .arb_is_sym(arb_is_sym), .arb_is_cnt(arb_is_cnt),
        .arb_is_seq_id(arb_is_seq_id), .arb_is_eob(arb_is_eob), .arb_is_src(arb_is_src),
        .is_arb_rd(is_arb_rd), .blk_done(blk_done), .blk_done_src(blk_done_src),
        .err_seq(err_seq)
    );

    typedef struct {
        bit [7:0]  sym;
        bit [15:0] cnt;
        bit [7:0]  seq;
        bit        eob;
        bit        src;
    } w_t;

    w_t p0[$], p1[$], mq[$];
    int lock, rr_m;
    bit [7:0] rec_m;
    bit err_m, done_m, done_src_m;
    int gap0, gap1, rd_mode;
    bit last_rd0, last_rd1, last_vld, last_err;
    int done_log[$];
    int deliv, added;
    int checks = 0;
    int errors = 0;

    task automatic add_block(int p, int len, bit [7:0] seq);
        w_t w;
        for (int i = 0; i < len; i++) begin
            w.sym = 8'($urandom);
            w.cnt = 16'($urandom);
            w.seq = seq;
            w.eob = (i == len - 1);
            w.src = p[0];
            if (p == 0) p0.push_back(w); else p1.push_back(w);
            added++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_vld = 0; req1_vld = 0; is_arb_rd = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        mq.delete(); p0.delete(); p1.delete(); done_log.delete();
        lock = -1; rr_m = 0; rec_m = 0; err_m = 0; done_m = 0; done_src_m = 0;
        deliv = 0; added = 0; gap0 = 0; gap1 = 0; rd_mode = 0;
    endtask

    // One clock: drive producers/engine, compare outputs against the model, then advance it
    task automatic step();
        w_t h0, h1, hd, z;
        bit v0, v1, eng, e0, e1, nd, nds;
        int g;
        z = '{default: 0};
        @(negedge clk);
        h0 = (p0.size() > 0) ? p0[0] : z;
        h1 = (p1.size() > 0) ? p1[0] : z;
        v0 = (p0.size() > 0) && ($urandom_range(99) >= gap0);
        v1 = (p1.size() > 0) && ($urandom_range(99) >= gap1);
        req0_vld = v0; req0_sym = h0.sym; req0_cnt = h0.cnt; req0_seq_id = h0.seq; req0_eob = h0.eob;
        req1_vld = v1; req1_sym = h1.sym; req1_cnt = h1.cnt; req1_seq_id = h1.seq; req1_eob = h1.eob;
        is_arb_rd = (rd_mode == 0) ? 1'b1 : (rd_mode == 2) ? 1'b0 : 1'($urandom_range(1));
        #1;
        eng = is_arb_rd && (mq.size() > 0);
        e0 = (lock == 0) && v0 && (mq.size() < 2 || eng);
        e1 = (lock == 1) && v1 && (mq.size() < 2 || eng);
        checks++;
        if (req0_rd !== e0) begin errors++; $display("FAIL req0_rd got %0b exp %0b t=%0t", req0_rd, e0, $time); end
        checks++;
        if (req1_rd !== e1) begin errors++; $display("FAIL req1_rd got %0b exp %0b t=%0t", req1_rd, e1, $time); end
        checks++;
        if (arb_is_vld !== (mq.size() > 0)) begin
            errors++; $display("FAIL arb_is_vld got %0b exp %0b t=%0t", arb_is_vld, mq.size() > 0, $time);
        end
        if (mq.size() > 0) begin
            checks++;
            if ({arb_is_sym, arb_is_cnt, arb_is_seq_id, arb_is_eob, arb_is_src} !==
                {mq[0].sym, mq[0].cnt, mq[0].seq, mq[0].eob, mq[0].src}) begin
                errors++;
                $display("FAIL head_word got %0h/%0h/%0h/%0b/%0b exp %0h/%0h/%0h/%0b/%0b t=%0t",
                         arb_is_sym, arb_is_cnt, arb_is_seq_id, arb_is_eob, arb_is_src,
                         mq[0].sym, mq[0].cnt, mq[0].seq, mq[0].eob, mq[0].src, $time);
            end
        end
        checks++;
        if (blk_done !== done_m) begin errors++; $display("FAIL blk_done got %0b exp %0b t=%0t", blk_done, done_m, $time); end
        if (done_m) begin
            checks++;
            if (blk_done_src !== done_src_m) begin
                errors++; $display("FAIL blk_done_src got %0b exp %0b t=%0t", blk_done_src, done_src_m, $time);
            end
        end
        checks++;
        if (err_seq !== err_m) begin errors++; $display("FAIL err_seq got %0b exp %0b t=%0t", err_seq, err_m, $time); end
        last_rd0 = req0_rd; last_rd1 = req1_rd; last_vld = arb_is_vld; last_err = err_seq;
        if (blk_done) done_log.push_back(int'(blk_done_src));
        if (arb_is_vld && is_arb_rd) deliv++;

        nd = 0; nds = 0;
        if (eng) begin
            hd = mq.pop_front();
            nd = hd.eob; nds = hd.src;
        end
        if (lock < 0) begin
            g = -1;
            if (v0 && !v1) g = 0;
            else if (v1 && !v0) g = 1;
            else if (v0 && v1) g = rr_m;
            if (g >= 0) begin
                lock = g;
                rec_m = (g == 0) ? h0.seq : h1.seq;
            end
        end else if (e0 || e1) begin
            hd = e0 ? p0.pop_front() : p1.pop_front();
            if (hd.seq != rec_m) err_m = 1;
            mq.push_back(hd);
            if (hd.eob) begin
                rr_m = (lock == 0) ? 1 : 0;
                lock = -1;
            end
        end
        done_m = nd;
        if (nd) done_src_m = nds;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({req0_rd, req1_rd, arb_is_vld, blk_done, blk_done_src, err_seq} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {req0_rd, req1_rd, arb_is_vld, blk_done, blk_done_src, err_seq});
        end
        checks++;
        if ({arb_is_sym, arb_is_cnt, arb_is_seq_id, arb_is_eob, arb_is_src} !== 34'b0) begin
            errors++;
            $display("FAIL reset_data got %0h exp 0", {arb_is_sym, arb_is_cnt, arb_is_seq_id, arb_is_eob, arb_is_src});
        end
    endtask

    task automatic test_back_to_back();
        int last0, first1;
        do_reset();
        add_block(0, 3, 8'h21);
        add_block(1, 3, 8'h22);
        last0 = -1; first1 = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (last_rd0) last0 = c;
            if (last_rd1 && first1 < 0) first1 = c;
        end
        checks++;
        if (last0 != 3 || first1 != 5) begin
            errors++; $display("FAIL b2b_bubble got last0=%0d first1=%0d exp 3 5", last0, first1);
        end
        checks++;
        if (done_log.size() != 2 || done_log[0] != 0 || done_log[1] != 1) begin
            errors++; $display("FAIL b2b_done_order got n=%0d exp 2 (src 0 then 1)", done_log.size());
        end
    endtask

    task automatic test_rr_single();
        int first;
        do_reset();
        add_block(1, 2, 8'h31);
        for (int c = 0; c < 5; c++) step();
        add_block(0, 2, 8'h32);
        add_block(1, 2, 8'h33);
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            step();
            if (last_rd0) first = 0;
            else if (last_rd1) first = 1;
        end
        checks++;
        if (first != 0) begin errors++; $display("FAIL rr_after_single got %0d exp 0", first); end
        for (int c = 0; c < 8; c++) step();
    endtask

    task automatic test_stall();
        int pops;
        do_reset();
        rd_mode = 2;
        add_block(0, 4, 8'h41);
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (last_rd0) pops++;
        end
        checks++;
        if (pops != 2) begin errors++; $display("FAIL stall_pops got %0d exp 2", pops); end
        checks++;
        if (last_rd0 !== 1'b0) begin errors++; $display("FAIL stall_rd got %0b exp 0", last_rd0); end
        rd_mode = 0;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (deliv != 4) begin errors++; $display("FAIL stall_deliver got %0d exp 4", deliv); end
    endtask

    task automatic test_single_word();
        int n;
        bit alt;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_block(0, 1, 8'(8'h60 + i));
            add_block(1, 1, 8'(8'h70 + i));
        end
        n = 0;
        while ((p0.size() > 0 || p1.size() > 0) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 16) begin errors++; $display("FAIL single_word_cycles got %0d exp 16", n); end
        for (int c = 0; c < 4; c++) step();
        alt = (done_log.size() == 8);
        for (int i = 0; i < done_log.size(); i++) if (done_log[i] != (i % 2)) alt = 0;
        checks++;
        if (!alt) begin errors++; $display("FAIL single_word_alternation got n=%0d exp 8 alternating", done_log.size()); end
    endtask

    task automatic test_seq_err();
        do_reset();
        add_block(0, 2, 8'h11);
        p0[1].seq = 8'h12;
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (last_err !== 1'b0) begin errors++; $display("FAIL seq_err_early got %0b exp 0", last_err); end
        step();
        checks++;
        if (last_err !== 1'b1) begin errors++; $display("FAIL seq_err_rise got %0b exp 1", last_err); end
        add_block(1, 2, 8'h55);
        for (int c = 0; c < 6; c++) step();
        checks++;
        if (last_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky got %0b exp 1", last_err); end
        do_reset();
        step();
        checks++;
        if (last_err !== 1'b0) begin errors++; $display("FAIL seq_err_clear got %0b exp 0", last_err); end
    endtask

    task automatic test_reset_mid();
        int first;
        do_reset();
        rd_mode = 2;
        add_block(0, 5, 8'h51);
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (last_vld !== 1'b1 || mq.size() != 2) begin
            errors++; $display("FAIL reset_mid_fill got vld=%0b model=%0d exp 1 2", last_vld, mq.size());
        end
        do_reset();
        step();
        checks++;
        if (last_vld !== 1'b0) begin errors++; $display("FAIL reset_mid_flush got %0b exp 0", last_vld); end
        add_block(1, 2, 8'h52);
        add_block(0, 2, 8'h53);
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            step();
            if (last_rd0) first = 0;
            else if (last_rd1) first = 1;
        end
        checks++;
        if (first != 0) begin errors++; $display("FAIL reset_mid_rr got %0d exp 0", first); end
        for (int c = 0; c < 8; c++) step();
    endtask

    task automatic test_random();
        int len;
        do_reset();
        gap0 = 20; gap1 = 20; rd_mode = 1;
        for (int c = 0; c < 800; c++) begin
            if (p0.size() == 0 && $urandom_range(3) == 0) begin
                len = $urandom_range(4, 1);
                add_block(0, len, 8'($urandom));
                if ($urandom_range(9) == 0) p0[p0.size() - 1].seq ^= 8'h01;
            end
            if (p1.size() == 0 && $urandom_range(3) == 0) begin
                len = $urandom_range(4, 1);
                add_block(1, len, 8'($urandom));
                if ($urandom_range(9) == 0) p1[p1.size() - 1].seq ^= 8'h01;
            end
            step();
        end
        gap0 = 0; gap1 = 0; rd_mode = 0;
        for (int c = 0; c < 40; c++) step();
        checks++;
        if (deliv != added) begin errors++; $display("FAIL random_deliver got %0d exp %0d", deliv, added); end
    endtask

    initial begin
        rst = 1'b1;
        req0_vld = 0; req0_sym = 0; req0_cnt = 0; req0_seq_id = 0; req0_eob = 0;
        req1_vld = 0; req1_sym = 0; req1_cnt = 0; req1_seq_id = 0; req1_eob = 0;
        is_arb_rd = 0;
        test_reset();
        test_back_to_back();
        test_rr_single();
        test_stall();
        test_single_word();
        test_seq_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
